// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control sequencer.
// Optional ILLEGAL_TRAP_EN: illegal op (6'h3F) halts the core instead of being skipped.
module core_seq_ctrl #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir,
  input  logic [5:0]        dec_op,
  input  logic              dec_use_imm,
  output logic [5:0]        alu_op,
  output logic              alu_src_imm,
  output logic              rf_we,
  output logic              retire,
  output logic [31:0]       retire_cnt,
  output logic              halted
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_e;
  localparam logic [5:0] OP_ILL = 6'h3F;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [31:0]       ir_q, ir_d, cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic              imm_q, imm_d, en_q;
  // Word-granular increment keeps pc[1:0] at zero and wraps naturally.
  assign pc_inc = {pc_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      op_q    <= OP_ILL;
      imm_q   <= 1'b0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      en_q    <= 1'b1;
    end
  end
  // en_q holds off the first fetch until the cycle after reset is released.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_d    = op_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_FETCH: if (en_q && imem_ready) begin
        ir_d    = imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d  = dec_op;
        imm_d = dec_use_imm;
        if (dec_op == OP_ILL) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
          pc_d    = pc_inc;
`endif
        end else state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        pc_d    = pc_inc;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_FETCH;
      end
      default: ;
    endcase
  end
  always_comb begin
    imem_req    = (state_q == S_FETCH) && en_q;
    imem_addr   = pc_q;
    ir          = ir_q;
    alu_op      = op_q;
    alu_src_imm = imm_q;
    rf_we       = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
    retire      = state_q == S_WB;
    retire_cnt  = cnt_q;
`ifdef ILLEGAL_TRAP_EN
    halted      = state_q == S_HALT;
`else
    halted      = 1'b0;
`endif
  end
endmodule
